ibex_dbus_arb: RTL and testbench

IBEX_DBUS_ARB -- requirements
Module: ibex_dbus_arb

---
 rtl/ibex_dbus_arb.sv | 141 ++++++++++++++
 tb/tb_ibex_dbus_arb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ibex_dbus_arb.sv
// Two-port data-bus arbiter: the core LSU (port 0) and debug SBA (port 1) share one bus.
// Responses are routed back in grant order through a small owner FIFO.
module ibex_dbus_arb #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_gnt_o,
    output logic        lsu_rvalid_o,
    output logic        lsu_err_o,
    output logic [31:0] lsu_rdata_o,

    input  logic        sba_req_i,
    input  logic        sba_we_i,
    input  logic [3:0]  sba_be_i,
    input  logic [31:0] sba_addr_i,
    input  logic [31:0] sba_wdata_i,
    output logic        sba_gnt_o,
    output logic        sba_rvalid_o,
    output logic        sba_err_o,
    output logic [31:0] sba_rdata_o,

    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic        data_err_i,
    input  logic [31:0] data_rdata_i,

    output logic        unexpected_rsp_o
);

    localparam int unsigned     PtrW    = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [2:0]      MaxCnt  = 3'(MaxOutstanding);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(MaxOutstanding - 1);

    logic [2:0]      count_q;
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic            owner_q [MaxOutstanding];
    logic            lock_q;
    logic            lock_port_q;
    logic            last_gnt_q;
    logic            unexp_q;

    logic            sel;
    logic            push;
    logic            pop;
    logic            head_owner;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // A locked port keeps the bus only while it still requests; a dropped request re-arbitrates.
    always_comb begin
        sel = sba_req_i;
        if (lock_q && (lock_port_q ? sba_req_i : lsu_req_i)) begin
            sel = lock_port_q;
        end else if (lsu_req_i && sba_req_i) begin
            sel = ~last_gnt_q;
        end
    end

    assign data_req_o = rst_ni & (lsu_req_i | sba_req_i) & (count_q < MaxCnt);
    assign push       = data_req_o & data_gnt_i;
    assign pop        = data_rvalid_i & (count_q != 3'd0);
    assign head_owner = owner_q[rd_ptr_q];

    always_comb begin
        data_we_o    = 1'b0;
        data_be_o    = 4'h0;
        data_addr_o  = 32'h0;
        data_wdata_o = 32'h0;
        if (data_req_o) begin
            data_we_o    = sel ? sba_we_i    : lsu_we_i;
            data_be_o    = sel ? sba_be_i    : lsu_be_i;
            data_addr_o  = sel ? sba_addr_i  : lsu_addr_i;
            data_wdata_o = sel ? sba_wdata_i : lsu_wdata_i;
        end
    end

    assign lsu_gnt_o    = push & ~sel;
    assign sba_gnt_o    = push & sel;
    assign lsu_rvalid_o = pop & ~head_owner;
    assign sba_rvalid_o = pop & head_owner;
    assign lsu_err_o    = lsu_rvalid_o & data_err_i;
    assign sba_err_o    = sba_rvalid_o & data_err_i;
    assign lsu_rdata_o  = lsu_rvalid_o ? data_rdata_i : 32'h0;
    assign sba_rdata_o  = sba_rvalid_o ? data_rdata_i : 32'h0;

    assign unexpected_rsp_o = unexp_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q     <= 3'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            lock_q      <= 1'b0;
            lock_port_q <= 1'b0;
            last_gnt_q  <= 1'b1;
            unexp_q     <= 1'b0;
            for (int i = 0; i < int'(MaxOutstanding); i++) begin
                owner_q[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                owner_q[wr_ptr_q] <= sel;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                last_gnt_q        <= sel;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
            if (data_req_o && !data_gnt_i) begin
                lock_q      <= 1'b1;
                lock_port_q <= sel;
            end else begin
                lock_q <= 1'b0;
            end
            if (data_rvalid_i && (count_q == 3'd0)) begin
                unexp_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibex_dbus_arb.sv
// Directed bench for ibex_dbus_arb: a cycle table from reset, then hand sequences
// for contention order, lock, reset with transactions outstanding and dropped requests.
module tb_ibex_dbus_arb;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lsu_req_i, lsu_we_i, sba_req_i, sba_we_i;
    logic [3:0]  lsu_be_i, sba_be_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, sba_addr_i, sba_wdata_i;
    logic        lsu_gnt_o, lsu_rvalid_o, lsu_err_o, sba_gnt_o, sba_rvalid_o, sba_err_o;
    logic [31:0] lsu_rdata_o, sba_rdata_o;
    logic        data_req_o, data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o, data_wdata_o;
    logic        data_gnt_i, data_rvalid_i, data_err_i;
    logic [31:0] data_rdata_i;
    logic        unexpected_rsp_o;

    always #5 clk_i = ~clk_i;

    ibex_dbus_arb #(.MaxOutstanding(2)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_err_o(lsu_err_o),
        .lsu_rdata_o(lsu_rdata_o),
        .sba_req_i(sba_req_i), .sba_we_i(sba_we_i), .sba_be_i(sba_be_i),
        .sba_addr_i(sba_addr_i), .sba_wdata_i(sba_wdata_i),
        .sba_gnt_o(sba_gnt_o), .sba_rvalid_o(sba_rvalid_o), .sba_err_o(sba_err_o),
        .sba_rdata_o(sba_rdata_o),
        .data_req_o(data_req_o), .data_we_o(data_we_o), .data_be_o(data_be_o),
        .data_addr_o(data_addr_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i),
        .data_rdata_i(data_rdata_i),
        .unexpected_rsp_o(unexpected_rsp_o)
    );

    // fl = {data_req, lsu_gnt, sba_gnt, lsu_rvalid, sba_rvalid, lsu_err, sba_err, unexpected}
    // src: 0 = bus idle (attributes 0), 1 = LSU attributes expected, 2 = SBA attributes expected
    typedef struct {
        logic        lr, sr, g, rv, er;
        logic [31:0] rd;
        logic [7:0]  fl;
        int          src;
    } vec_t;

    vec_t tbl [17];
    int   n_pass = 0;
    int   n_chk  = 0;

    function automatic logic [140:0] act_vec();
        return {data_req_o, lsu_gnt_o, sba_gnt_o, lsu_rvalid_o, sba_rvalid_o, lsu_err_o,
                sba_err_o, unexpected_rsp_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
                lsu_rdata_o, sba_rdata_o};
    endfunction

    function automatic logic [140:0] exp_vec(input logic [7:0] fl, input int src,
                                             input logic [31:0] rd);
        logic [31:0] a, wd, lrd, srd;
        logic        we;
        logic [3:0]  be;
        a = 32'h0; wd = 32'h0; we = 1'b0; be = 4'h0;
        if (src == 1) begin
            a = lsu_addr_i; wd = lsu_wdata_i; we = lsu_we_i; be = lsu_be_i;
        end else if (src == 2) begin
            a = sba_addr_i; wd = sba_wdata_i; we = sba_we_i; be = sba_be_i;
        end
        lrd = fl[4] ? rd : 32'h0;
        srd = fl[3] ? rd : 32'h0;
        return {fl, a, we, be, wd, lrd, srd};
    endfunction

    task automatic step(input string name, input logic rst, input logic lr, input logic sr,
                        input logic g, input logic rv, input logic er, input logic [31:0] rd,
                        input logic [7:0] fl, input int src);
        logic [140:0] act, exp;
        @(negedge clk_i);
        rst_ni = rst; lsu_req_i = lr; sba_req_i = sr;
        data_gnt_i = g; data_rvalid_i = rv; data_err_i = er; data_rdata_i = rd;
        #1;
        act = act_vec();
        exp = exp_vec(fl, src, rd);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        lsu_req_i = 0; sba_req_i = 0; data_gnt_i = 0; data_rvalid_i = 0;
        data_err_i = 0; data_rdata_i = 0;
        lsu_we_i = 1'b0; lsu_be_i = 4'hF; lsu_addr_i = 32'h100; lsu_wdata_i = 32'h1111_1111;
        sba_we_i = 1'b1; sba_be_i = 4'h3; sba_addr_i = 32'h200; sba_wdata_i = 32'h2222_2222;

        //           lr  sr  g   rv  er  rdata         flags        src
        tbl[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        8'b0000_0000, 0};
        tbl[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,32'h0,        8'b1000_0000, 1};
        tbl[2]  = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        8'b1100_0000, 1};
        tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        8'b0000_0000, 0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'hDEADBEEF, 8'b0001_0000, 0};
        tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        8'b1010_0000, 2};
        tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        8'b1100_0000, 1};
        tbl[7]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        8'b0000_0000, 0};
        tbl[8]  = '{1'b1,1'b1,1'b0,1'b1,1'b0,32'hA1,       8'b0000_1000, 0};
        tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,32'hA2,       8'b1011_0100, 2};
        tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,32'h0,        8'b1100_0000, 1};
        tbl[11] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        8'b0000_0000, 0};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'hB1,       8'b0000_1000, 0};
        tbl[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'hB2,       8'b0001_0000, 0};
        tbl[14] = '{1'b0,1'b0,1'b0,1'b1,1'b0,32'hC3,       8'b0000_0000, 0};
        tbl[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        8'b0000_0001, 0};
        tbl[16] = '{1'b1,1'b0,1'b1,1'b0,1'b0,32'h0,        8'b1100_0001, 1};

        step("reset_idle", 0, 0, 0, 0, 0, 0, 32'h0, 8'h00, 0);
        for (int i = 0; i < 17; i++) begin
            step($sformatf("table_row%0d", i), 1, tbl[i].lr, tbl[i].sr, tbl[i].g,
                 tbl[i].rv, tbl[i].er, tbl[i].rd, tbl[i].fl, tbl[i].src);
        end

        // Both ports request from reset with gnt always high: grants alternate 0,1,0,1.
        step("contend_in_reset", 0, 1, 1, 1, 1, 0, 32'h0,  8'b0000_0000, 0);
        step("contend_gnt0",     1, 1, 1, 1, 0, 0, 32'h0,  8'b1100_0000, 1);
        step("contend_gnt1",     1, 1, 1, 1, 1, 0, 32'h10, 8'b1011_0000, 2);
        step("contend_gnt2",     1, 1, 1, 1, 1, 0, 32'h11, 8'b1100_1000, 1);
        step("contend_gnt3",     1, 1, 1, 1, 1, 0, 32'h12, 8'b1011_0000, 2);
        step("contend_last_rsp", 1, 0, 0, 0, 1, 0, 32'h13, 8'b0000_1000, 0);

        // LSU granted last so SBA would win contention; the lock must keep the LSU.
        step("lock_prime_gnt",   1, 1, 0, 1, 0, 0, 32'h0,  8'b1100_0000, 1);
        step("lock_prime_rsp",   1, 0, 0, 0, 1, 0, 32'h20, 8'b0001_0000, 0);
        lsu_addr_i = 32'h300;
        step("lock_stall1",      1, 1, 0, 0, 0, 0, 32'h0,  8'b1000_0000, 1);
        for (int c = 2; c <= 5; c++) begin
            step($sformatf("lock_stall%0d", c), 1, 1, 1, 0, 0, 0, 32'h0, 8'b1000_0000, 1);
        end
        step("lock_lsu_gnt",     1, 1, 1, 1, 0, 0, 32'h0,  8'b1100_0000, 1);
        step("lock_sba_gnt",     1, 0, 1, 1, 0, 0, 32'h0,  8'b1010_0000, 2);

        // Two outstanding: reset drops everything, late rvalid becomes unexpected.
        step("reset_midop",      0, 1, 0, 0, 1, 0, 32'h30, 8'b0000_0000, 0);
        step("late_rsp",         1, 0, 0, 0, 1, 0, 32'h31, 8'b0000_0000, 0);
        step("unexp_set",        1, 0, 0, 0, 0, 0, 32'h0,  8'b0000_0001, 0);
        step("unexp_sticky",     1, 0, 0, 0, 0, 0, 32'h0,  8'b0000_0001, 0);

        // LSU drops its request before gnt: SBA takes the bus and no LSU push happens.
        step("drop_lsu_req",     1, 1, 0, 0, 0, 0, 32'h0,  8'b1000_0001, 1);
        step("drop_sba_gnt",     1, 0, 1, 1, 0, 0, 32'h0,  8'b1010_0001, 2);
        step("drop_rsp_to_sba",  1, 0, 0, 0, 1, 0, 32'h40, 8'b0000_1001, 0);
        step("unexp_cleared",    0, 0, 0, 0, 0, 0, 32'h0,  8'b0000_0000, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
